// File: rtl/axis_video_pkg.sv
// Shared definitions for the AXI4-Stream video test-pattern generator:
// pattern codes, colour-bar palette and control state encoding.
package axis_video_pkg;

   localparam logic [1:0] PAT_SOLID = 2'd0;
   localparam logic [1:0] PAT_BARS  = 2'd1;
   localparam logic [1:0] PAT_RAMP  = 2'd2;
   localparam logic [1:0] PAT_CHECK = 2'd3;

   // SMPTE-style bar order, left to right, packed as {R, G, B}
   localparam logic [23:0] BAR_RGB [8] = '{
      24'hFFFFFF,
      24'hFFFF00,
      24'h00FFFF,
      24'h00FF00,
      24'hFF00FF,
      24'hFF0000,
      24'h0000FF,
      24'h000000
   };

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } tpg_state_e;

endpackage

// File: rtl/tpg_pixel_gen.sv
// Combinational colour lookup: turns the pattern select and the pixel position
// (plus the precomputed bar index) into a 24-bit {R, G, B} value.
module tpg_pixel_gen
   import axis_video_pkg::*;
(
   input  logic [1:0]  pattern,
   input  logic [7:0]  x_lsb,
   input  logic        x_bit4,
   input  logic        y_bit4,
   input  logic [2:0]  bar_idx,
   input  logic [23:0] solid_rgb,
   output logic [23:0] rgb
);

   // Ramp uses the low byte of x so it wraps every 256 pixels; the checker
   // toggles every 16 pixels/lines, so only bit 4 of each coordinate matters.
   always_comb begin
      rgb = solid_rgb;
      case (pattern)
         PAT_SOLID: rgb = solid_rgb;
         PAT_BARS:  rgb = BAR_RGB[bar_idx];
         PAT_RAMP:  rgb = {x_lsb, x_lsb, x_lsb};
         PAT_CHECK: rgb = (x_bit4 ^ y_bit4) ? 24'hFFFFFF : 24'h000000;
         default:   rgb = solid_rgb;
      endcase
   end

endmodule

// File: rtl/axis_video_tpg.sv
// AXI4-Stream RGB test-pattern generator: owns the frame/line counters, the
// IDLE/ACTIVE control and the registered output beat; colours come from tpg_pixel_gen.
module axis_video_tpg
   import axis_video_pkg::*;
#(
   parameter int DATAW = 24,
   parameter int DIMW  = 12
) (
   input  logic               aclk,
   input  logic               aresetn,
   input  logic               en,
   input  logic [1:0]         pattern,
   input  logic [DIMW-1:0]    hsize,
   input  logic [DIMW-1:0]    vsize,
   input  logic [23:0]        solid_rgb,
   output logic [DATAW-1:0]   m_axis_tdata,
   output logic               m_axis_tvalid,
   input  logic               m_axis_tready,
   output logic               m_axis_tuser,
   output logic               m_axis_tlast,
   output logic [DATAW/8-1:0] m_axis_tstrb,
   output logic [DATAW/8-1:0] m_axis_tkeep,
   output logic               m_axis_tid,
   output logic               m_axis_tdest,
   output logic               busy,
   output logic [15:0]        frame_cnt
);

   tpg_state_e state_q, state_d;

   logic [1:0]       cfg_pattern;
   logic [DIMW-1:0]  cfg_hsize, cfg_vsize, cfg_bw;
   logic [23:0]      cfg_solid;

   logic [DIMW-1:0]  x_q, y_q, bar_cnt_q;
   logic [2:0]       bar_idx_q;

   logic [DATAW-1:0] tdata_q;
   logic             tvalid_q, tuser_q, tlast_q;
   logic [15:0]      frame_cnt_q;

   logic             live_ok, handshake, line_end, frame_end, last_beat, advance;
   logic             start_frame;
   logic [DIMW-1:0]  live_bw;
   logic [DIMW-1:0]  nxt_x, nxt_y, nxt_bar_cnt;
   logic [2:0]       nxt_bar_idx;
   logic             nxt_last;
   logic [1:0]       gen_pattern;
   logic [23:0]      gen_solid, gen_rgb;

   assign live_ok   = en && (hsize != '0) && (vsize != '0);
   assign handshake = tvalid_q && m_axis_tready;
   assign line_end  = (x_q == cfg_hsize - DIMW'(1));
   assign frame_end = line_end && (y_q == cfg_vsize - DIMW'(1));
   assign last_beat = handshake && frame_end;
   assign advance   = handshake && !frame_end;

   // Bars are hsize/8 wide; narrow frames fall back to 1-pixel bars
   assign live_bw = (hsize < DIMW'(8)) ? DIMW'(1) : (hsize >> 3);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A new frame starts from IDLE, or back-to-back on the last-pixel handshake
   always_comb begin
      state_d     = state_q;
      start_frame = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (live_ok) begin
               state_d     = ST_ACTIVE;
               start_frame = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (last_beat) begin
               if (live_ok) begin
                  start_frame = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Position of the beat that will be loaded next: pixel (0,0) of a fresh
   // frame using the live inputs, or the successor of the current pixel.
   always_comb begin
      nxt_x       = '0;
      nxt_y       = '0;
      nxt_bar_cnt = '0;
      nxt_bar_idx = '0;
      gen_pattern = pattern;
      gen_solid   = solid_rgb;
      nxt_last    = (hsize == DIMW'(1));
      if (!start_frame) begin
         gen_pattern = cfg_pattern;
         gen_solid   = cfg_solid;
         if (line_end) begin
            nxt_y = y_q + DIMW'(1);
         end else begin
            nxt_x = x_q + DIMW'(1);
            nxt_y = y_q;
            if (bar_cnt_q == cfg_bw - DIMW'(1)) begin
               nxt_bar_idx = (bar_idx_q == 3'd7) ? 3'd7 : bar_idx_q + 3'd1;
            end else begin
               nxt_bar_cnt = bar_cnt_q + DIMW'(1);
               nxt_bar_idx = bar_idx_q;
            end
         end
         nxt_last = (nxt_x == cfg_hsize - DIMW'(1));
      end
   end

   tpg_pixel_gen u_pixel_gen (
      .pattern   (gen_pattern),
      .x_lsb     (nxt_x[7:0]),
      .x_bit4    (nxt_x[4]),
      .y_bit4    (nxt_y[4]),
      .bar_idx   (nxt_bar_idx),
      .solid_rgb (gen_solid),
      .rgb       (gen_rgb)
   );

   // The output beat only changes on a frame start or a handshake, so it is
   // held stable while the downstream stalls.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cfg_pattern <= PAT_SOLID;
         cfg_hsize   <= '0;
         cfg_vsize   <= '0;
         cfg_bw      <= '0;
         cfg_solid   <= '0;
         x_q         <= '0;
         y_q         <= '0;
         bar_cnt_q   <= '0;
         bar_idx_q   <= '0;
         tdata_q     <= '0;
         tvalid_q    <= 1'b0;
         tuser_q     <= 1'b0;
         tlast_q     <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         if (start_frame) begin
            cfg_pattern <= pattern;
            cfg_hsize   <= hsize;
            cfg_vsize   <= vsize;
            cfg_bw      <= live_bw;
            cfg_solid   <= solid_rgb;
            x_q         <= '0;
            y_q         <= '0;
            bar_cnt_q   <= '0;
            bar_idx_q   <= '0;
            tdata_q     <= gen_rgb;
            tvalid_q    <= 1'b1;
            tuser_q     <= 1'b1;
            tlast_q     <= nxt_last;
         end else if (advance) begin
            x_q         <= nxt_x;
            y_q         <= nxt_y;
            bar_cnt_q   <= nxt_bar_cnt;
            bar_idx_q   <= nxt_bar_idx;
            tdata_q     <= gen_rgb;
            tuser_q     <= 1'b0;
            tlast_q     <= nxt_last;
         end else if (last_beat) begin
            tvalid_q    <= 1'b0;
            tuser_q     <= 1'b0;
            tlast_q     <= 1'b0;
         end
         if (last_beat) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tuser  = tuser_q;
   assign m_axis_tlast  = tlast_q;
   assign m_axis_tstrb  = '1;
   assign m_axis_tkeep  = '1;
   assign m_axis_tid    = 1'b0;
   assign m_axis_tdest  = 1'b0;
   assign busy          = (state_q == ST_ACTIVE);
   assign frame_cnt     = frame_cnt_q;

endmodule
